// File: rtl/cmd_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cmd_dispatcher_pkg
// Description : Shared constants for the command dispatcher. Includes the
//               opcodes, status codes, CDB field positions and FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_dispatcher_pkg;

  // Opcodes carried in CDB[7:0]
  localparam logic [7:0] OP_WRITE = 8'h40;  // host -> TBM
  localparam logic [7:0] OP_READ  = 8'h30;  // TBM -> host

  // Status codes as seen by the host in querydata[3:2]
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b11;
  localparam logic [1:0] ST_ERR  = 2'b10;

  // CDB field LSB positions and widths
  localparam int CDB_OP_LSB     = 0;
  localparam int CDB_OP_W       = 8;
  localparam int CDB_LBA_LSB    = 32;
  localparam int CDB_LBA_W      = 32;
  localparam int CDB_LBAHI_LSB  = 64;
  localparam int CDB_LBAHI_W    = 32;
  localparam int CDB_CNT_LSB    = 96;
  localparam int CDB_CNT_W      = 16;
  localparam int CDB_IDX_LSB    = 120;
  localparam int CDB_IDX_W      = 8;

  // Dispatcher FSM; S_IDLE must stay the all-zero encoding (reset state)
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_STATUS = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cmd_dispatcher_cdb_decode.sv
`default_nettype none
// ============================================================================
// Module      : cmd_dispatcher_cdb_decode
// Description : CDB decode. This is a purely combinational block. It extracts
//               the fields of a latched 256-bit CDB and flags whether the
//               command is legal. The range check is done in 33 bits, so an
//               LBA near the top of the 32-bit space cannot wrap back into
//               range.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_dispatcher_cdb_decode
  import cmd_dispatcher_pkg::*;
#(
  parameter logic [31:0] MAX_LBA = 32'h000F_FFFF
) (
  input  logic [255:0] cdb_i,
  output logic [31:0]  lba_o,
  output logic [15:0]  count_o,
  output logic [7:0]   index_o,
  output logic         is_write_o,
  output logic         legal_o
);

  logic [7:0]  w_opcode;
  logic [31:0] w_lba_hi;
  logic        w_op_ok;
  logic [32:0] w_last_lba;
  logic        w_unused_cdb;

  assign w_opcode   = cdb_i[CDB_OP_LSB    +: CDB_OP_W];
  assign lba_o      = cdb_i[CDB_LBA_LSB   +: CDB_LBA_W];
  assign w_lba_hi   = cdb_i[CDB_LBAHI_LSB +: CDB_LBAHI_W];
  assign count_o    = cdb_i[CDB_CNT_LSB   +: CDB_CNT_W];
  assign index_o    = cdb_i[CDB_IDX_LSB   +: CDB_IDX_W];

  // Reserved CDB bytes are carried but never interpreted
  assign w_unused_cdb = ^{cdb_i[255:128], cdb_i[119:112], cdb_i[31:8]};

  assign is_write_o = (w_opcode == OP_WRITE);
  assign w_op_ok    = (w_opcode == OP_WRITE) || (w_opcode == OP_READ);

  // Last block touched; only meaningful when count is non-zero
  assign w_last_lba = {1'b0, lba_o} + {17'b0, count_o} - 33'd1;

  assign legal_o = w_op_ok
                && (count_o != 16'd0)
                && (w_lba_hi == 32'd0)
                && (w_last_lba <= {1'b0, MAX_LBA});

endmodule
`default_nettype wire

// File: rtl/cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : cmd_dispatcher
// Description : Pops one CDB at a time from the ifq submission side. It
//               decodes the CDB and issues one TBM transfer request per
//               block, then posts busy/done/error status back to ifq. Only
//               one command is in flight at a time.
//               All outputs are registered. mem_req and its address are
//               loaded on the ISSUE->WAIT edge. As a result, the first
//               request rises two cycles after the edge that accepts the
//               CDB, and mem_req goes low for the single ISSUE cycle between
//               consecutive blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_dispatcher
  import cmd_dispatcher_pkg::*;
#(
  parameter int          BLOCK_SHIFT    = 4,
  parameter logic [31:0] MAX_LBA        = 32'h000F_FFFF,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic         clock_fpga,
  input  logic         reset,
  input  logic         sq_select,
  input  logic [255:0] cmd_in,
  output logic         sq_ack,
  output logic         status_update_enable,
  output logic [7:0]   cmdq_index,
  output logic [1:0]   status_code,
  output logic         mem_req,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  input  logic         mem_done
);

  localparam int            c_TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [c_TW-1:0] c_TIMER_ONE  = {{(c_TW-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [255:0]      cmd_q, cmd_d;
  logic [31:0]       lba_cur_q, lba_cur_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [c_TW-1:0]   timer_q, timer_d;
  logic [1:0]        final_q, final_d;

  logic              sq_ack_q, sq_ack_d;
  logic              sue_q, sue_d;
  logic [7:0]        cmdq_index_q, cmdq_index_d;
  logic [1:0]        status_code_q, status_code_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_write_q, mem_write_d;
  logic [31:0]       mem_addr_q, mem_addr_d;

  logic [31:0]       w_lba;
  logic [15:0]       w_count;
  logic [7:0]        w_index;
  logic              w_is_write;
  logic              w_legal;

  cmd_dispatcher_cdb_decode #(
    .MAX_LBA (MAX_LBA)
  ) u_cdb_decode (
    .cdb_i      (cmd_q),
    .lba_o      (w_lba),
    .count_o    (w_count),
    .index_o    (w_index),
    .is_write_o (w_is_write),
    .legal_o    (w_legal)
  );

  // Next-state and next-output logic for the dispatcher FSM
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    lba_cur_d     = lba_cur_q;
    remaining_d   = remaining_q;
    timer_d       = timer_q;
    final_d       = final_q;
    sq_ack_d      = 1'b0;
    sue_d         = 1'b0;
    cmdq_index_d  = cmdq_index_q;
    status_code_d = status_code_q;
    mem_req_d     = mem_req_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;

    case (state_q)
      S_IDLE: begin
        if (sq_select) begin
          cmd_d    = cmd_in;
          sq_ack_d = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        cmdq_index_d = w_index;
        if (w_legal) begin
          sue_d         = 1'b1;
          status_code_d = ST_BUSY;
          lba_cur_d     = w_lba;
          remaining_d   = w_count;
          state_d       = S_ISSUE;
        end else begin
          final_d = ST_ERR;
          state_d = S_STATUS;
        end
      end

      S_ISSUE: begin
        mem_req_d   = 1'b1;
        mem_write_d = w_is_write;
        mem_addr_d  = lba_cur_q << BLOCK_SHIFT;
        timer_d     = '0;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        // A completion arriving on the timeout cycle still counts as done
        if (mem_done) begin
          mem_req_d   = 1'b0;
          lba_cur_d   = lba_cur_q + 32'd1;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            final_d = ST_DONE;
            state_d = S_STATUS;
          end else begin
            state_d = S_ISSUE;
          end
        end else if (timer_q == c_TIMER_LAST) begin
          mem_req_d = 1'b0;
          final_d   = ST_ERR;
          state_d   = S_STATUS;
        end else begin
          timer_d = timer_q + c_TIMER_ONE;
        end
      end

      S_STATUS: begin
        sue_d         = 1'b1;
        status_code_d = final_q;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any command in flight
  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cmd_q         <= '0;
      lba_cur_q     <= '0;
      remaining_q   <= '0;
      timer_q       <= '0;
      final_q       <= '0;
      sq_ack_q      <= 1'b0;
      sue_q         <= 1'b0;
      cmdq_index_q  <= '0;
      status_code_q <= '0;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      lba_cur_q     <= lba_cur_d;
      remaining_q   <= remaining_d;
      timer_q       <= timer_d;
      final_q       <= final_d;
      sq_ack_q      <= sq_ack_d;
      sue_q         <= sue_d;
      cmdq_index_q  <= cmdq_index_d;
      status_code_q <= status_code_d;
      mem_req_q     <= mem_req_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
    end
  end

  assign sq_ack               = sq_ack_q;
  assign status_update_enable = sue_q;
  assign cmdq_index           = cmdq_index_q;
  assign status_code          = status_code_q;
  assign mem_req              = mem_req_q;
  assign mem_write            = mem_write_q;
  assign mem_address          = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_dispatcher
// Description : Self-checking bench for cmd_dispatcher. A negedge monitor logs
//               acks, status pulses and request rises. Each command's log is
//               compared with what the CDB rules say should happen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_dispatcher;

  localparam logic [31:0] MAX_LBA        = 32'h000F_FFFF;
  localparam int          TIMEOUT_CYCLES = 4096;
  localparam int          BLOCK_WORDS    = 16;

  logic         clock_fpga;
  logic         reset;
  logic         sq_select;
  logic [255:0] cmd_in;
  logic         mem_done;
  logic         sq_ack;
  logic         status_update_enable;
  logic [7:0]   cmdq_index;
  logic [1:0]   status_code;
  logic         mem_req;
  logic         mem_write;
  logic [31:0]  mem_address;

  cmd_dispatcher dut (
    .clock_fpga           (clock_fpga),
    .reset                (reset),
    .sq_select            (sq_select),
    .cmd_in               (cmd_in),
    .sq_ack               (sq_ack),
    .status_update_enable (status_update_enable),
    .cmdq_index           (cmdq_index),
    .status_code          (status_code),
    .mem_req              (mem_req),
    .mem_write            (mem_write),
    .mem_address          (mem_address),
    .mem_done             (mem_done)
  );

  initial begin
    clock_fpga = 1'b0;
    forever #5 clock_fpga = ~clock_fpga;
  end

  typedef struct packed {
    int unsigned cyc;
    logic [7:0]  idx;
    logic [1:0]  code;
  } st_ev_t;

  typedef struct packed {
    int unsigned cyc;
    logic        wr;
    logic [31:0] addr;
  } rq_ev_t;

  int unsigned ack_cyc[$];
  st_ev_t      st_q[$];
  rq_ev_t      rq_q[$];
  int unsigned cyc          = 0;
  int unsigned req_len      = 0;
  int unsigned last_req_len = 0;
  int unsigned last_fin_cyc = 0;
  logic        req_prev     = 1'b0;
  bit          respond_en   = 1'b0;
  int          n_checks     = 0;
  int          n_pass       = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Event log sampled on the falling edge
  initial begin
    st_ev_t se;
    rq_ev_t re;
    forever begin
      @(negedge clock_fpga);
      cyc++;
      if (sq_ack) ack_cyc.push_back(cyc);
      if (status_update_enable) begin
        se.cyc = cyc; se.idx = cmdq_index; se.code = status_code;
        st_q.push_back(se);
      end
      if (mem_req && !req_prev) begin
        re.cyc = cyc; re.wr = mem_write; re.addr = mem_address;
        rq_q.push_back(re);
      end
      if (mem_req) req_len++;
      else if (req_prev) begin
        last_req_len = req_len;
        req_len      = 0;
      end
      req_prev = mem_req;
    end
  end

  // Memory responder: random latency per request, occasional stray mem_done while idle
  initial begin
    int dly;
    bit seen;
    mem_done = 1'b0;
    dly      = 0;
    seen     = 1'b0;
    forever begin
      @(negedge clock_fpga);
      if (mem_req && !seen) begin
        dly  = $urandom_range(0, 6);
        seen = 1'b1;
      end
      if (!mem_req) seen = 1'b0;
      if (mem_done) mem_done = 1'b0;
      else if (respond_en && mem_req) begin
        if (dly == 0) mem_done = 1'b1;
        else dly--;
      end else if (respond_en && !mem_req && $urandom_range(0, 5) == 0) begin
        mem_done = 1'b1;
      end
    end
  end

  function automatic logic [255:0] mk_cdb(input logic [7:0] op, input logic [31:0] lba,
                                          input logic [31:0] hi, input logic [15:0] cnt,
                                          input logic [7:0] idx);
    logic [255:0] c;
    for (int i = 0; i < 8; i++) c[i*32 +: 32] = $urandom;
    c[7:0]     = op;
    c[63:32]   = lba;
    c[95:64]   = hi;
    c[111:96]  = cnt;
    c[127:120] = idx;
    return c;
  endfunction

  // Reference legality rule, in plain 64-bit arithmetic
  function automatic bit model_legal(input logic [255:0] c);
    longint unsigned lba, cnt;
    lba = 64'(c[63:32]);
    cnt = 64'(c[111:96]);
    if (c[7:0] != 8'h40 && c[7:0] != 8'h30) return 1'b0;
    if (cnt == 0) return 1'b0;
    if (c[95:64] != 32'd0) return 1'b0;
    return (lba + cnt - 1) <= 64'(MAX_LBA);
  endfunction

  task automatic run_cmd(input logic [255:0] cdb, input bit hold_next,
                         input logic [255:0] next_cdb, input bit stall);
    int         a0, s0, r0, fin, n_st_exp, n_rq_exp;
    bit         got, legal;
    logic [7:0] idx;
    logic [31:0] lba;
    logic [15:0] cnt;
    logic       wr;
    logic [1:0] exp_codes [2];

    a0 = ack_cyc.size();
    s0 = st_q.size();
    r0 = rq_q.size();
    respond_en = !stall;
    if (!(sq_select === 1'b1 && cmd_in === cdb)) begin
      sq_select = 1'b1;
      cmd_in    = cdb;
    end

    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock_fpga); #1;
      got = (ack_cyc.size() > a0);
    end
    check_eq("ack_seen", 64'(got), 64'd1);
    if (hold_next) cmd_in = next_cdb;
    else sq_select = 1'b0;

    fin = -1;
    for (int i = 0; i < 10000 && fin < 0; i++) begin
      @(negedge clock_fpga); #1;
      for (int k = s0; k < st_q.size(); k++)
        if (fin < 0 && st_q[k].code != 2'b01) fin = k;
    end
    got = (fin >= 0);
    check_eq("final_status_seen", 64'(got), 64'd1);
    if (!got) return;

    legal = model_legal(cdb);
    idx   = cdb[127:120];
    lba   = cdb[63:32];
    cnt   = cdb[111:96];
    wr    = (cdb[7:0] == 8'h40);
    exp_codes[0] = 2'b10;
    exp_codes[1] = 2'b10;
    if (!legal) begin
      n_st_exp = 1;
      n_rq_exp = 0;
    end else begin
      n_st_exp     = 2;
      exp_codes[0] = 2'b01;
      exp_codes[1] = stall ? 2'b10 : 2'b11;
      n_rq_exp     = stall ? 1 : int'(cnt);
    end

    check_eq("ack_count", 64'(ack_cyc.size() - a0), 64'd1);
    if (ack_cyc.size() > a0)
      check_eq("ack_after_prev_status", 64'(ack_cyc[a0] > last_fin_cyc), 64'd1);
    check_eq("status_pulses", 64'(fin - s0 + 1), 64'(n_st_exp));
    for (int k = 0; k < n_st_exp && s0 + k <= fin; k++)
      check_eq($sformatf("status[%0d]", k), 64'({st_q[s0+k].idx, st_q[s0+k].code}),
               64'({idx, exp_codes[k]}));
    check_eq("req_count", 64'(rq_q.size() - r0), 64'(n_rq_exp));
    for (int k = 0; k < n_rq_exp && r0 + k < rq_q.size(); k++)
      check_eq($sformatf("req[%0d]", k), 64'({rq_q[r0+k].wr, rq_q[r0+k].addr}),
               64'({wr, (lba + 32'(k)) * 32'(BLOCK_WORDS)}));
    check_eq("req_idle_after", 64'(mem_req), 64'd0);
    if (stall && legal)
      check_eq("timeout_req_len", 64'(last_req_len), 64'(TIMEOUT_CYCLES));
    last_fin_cyc = st_q[fin].cyc;
  endtask

  initial begin
    logic [255:0] cdb_a, cdb_b;
    logic [7:0]   op;
    logic [31:0]  lba, hi;
    logic [15:0]  cnt;
    bit           got;
    int           s0;

    reset     = 1'b0;
    sq_select = 1'b0;
    cmd_in    = '0;

    // Reset state
    repeat (3) @(negedge clock_fpga);
    #1;
    check_eq("reset_outputs", 64'({sq_ack, status_update_enable, cmdq_index, status_code,
                                   mem_req, mem_write, mem_address}), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock_fpga);
    #1;

    // Plain write and read
    run_cmd(mk_cdb(8'h40, 32'd0, 32'd0, 16'd8, 8'd1), 1'b0, '0, 1'b0);
    run_cmd(mk_cdb(8'h30, 32'd5, 32'd0, 16'd2, 8'd2), 1'b0, '0, 1'b0);

    // Illegal commands and range boundaries
    run_cmd(mk_cdb(8'h55, 32'd0, 32'd0, 16'd1, 8'd3), 1'b0, '0, 1'b0);
    run_cmd(mk_cdb(8'h40, 32'd0, 32'd0, 16'd0, 8'd4), 1'b0, '0, 1'b0);
    run_cmd(mk_cdb(8'h30, 32'd0, 32'd1, 16'd1, 8'd5), 1'b0, '0, 1'b0);
    run_cmd(mk_cdb(8'h40, MAX_LBA, 32'd0, 16'd2, 8'd6), 1'b0, '0, 1'b0);
    run_cmd(mk_cdb(8'h40, MAX_LBA, 32'd0, 16'd1, 8'd7), 1'b0, '0, 1'b0);
    run_cmd(mk_cdb(8'h30, 32'hFFFF_FFFF, 32'd0, 16'd1, 8'd8), 1'b0, '0, 1'b0);
    run_cmd(mk_cdb(8'h30, 32'hFFFF_FFF0, 32'd0, 16'hFFFF, 8'd9), 1'b0, '0, 1'b0);

    // Timeout, then a normal command must still be accepted
    run_cmd(mk_cdb(8'h40, 32'd10, 32'd0, 16'd2, 8'd10), 1'b0, '0, 1'b1);
    run_cmd(mk_cdb(8'h30, 32'd20, 32'd0, 16'd1, 8'd11), 1'b0, '0, 1'b0);

    // Back-pressure: sq_select held across a whole command
    cdb_a = mk_cdb(8'h40, 32'd100, 32'd0, 16'd3, 8'd12);
    cdb_b = mk_cdb(8'h30, 32'd200, 32'd0, 16'd2, 8'd13);
    run_cmd(cdb_a, 1'b1, cdb_b, 1'b0);
    run_cmd(cdb_b, 1'b0, '0, 1'b0);

    // Randomized commands
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 8'h40;
        4, 5, 6, 7: op = 8'h30;
        default:    op = 8'($urandom);
      endcase
      lba = ($urandom_range(0, 3) == 0) ? MAX_LBA - 32'($urandom_range(0, 4))
                                        : 32'($urandom_range(0, 1000));
      hi  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
      cnt = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      run_cmd(mk_cdb(op, lba, hi, cnt, 8'($urandom)), 1'b0, '0, 1'b0);
    end

    // Reset while waiting on a block
    respond_en = 1'b0;
    sq_select  = 1'b1;
    cmd_in     = mk_cdb(8'h40, 32'd300, 32'd0, 16'd4, 8'h33);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock_fpga); #1;
      got = mem_req;
    end
    sq_select = 1'b0;
    check_eq("rst_req_before", 64'(got), 64'd1);
    repeat (3) @(negedge clock_fpga);
    #1;
    s0    = st_q.size();
    reset = 1'b0;
    #1;
    check_eq("rst_async_outputs", 64'({sq_ack, status_update_enable, cmdq_index, status_code,
                                       mem_req, mem_write, mem_address}), 64'd0);
    repeat (3) @(negedge clock_fpga);
    #1;
    reset = 1'b1;
    repeat (5) @(negedge clock_fpga);
    #1;
    check_eq("rst_no_status", 64'(st_q.size() - s0), 64'd0);
    run_cmd(mk_cdb(8'h30, 32'd7, 32'd0, 16'd3, 8'h44), 1'b0, '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
